// File: rtl/obuf_pkg.sv
// Shared types and helpers for the IFFT ping-pong output buffer.
// round_sat is only referenced when OBUF_SHIFT_EN is defined.
package obuf_pkg;

  typedef enum logic [1:0] {EMPTY, FULL, DRAIN} bank_state_e;

  function automatic bank_state_e next_bank_state(bank_state_e cur, logic load,
                                                  logic promote, logic finish);
    case (cur)
      EMPTY:   return load ? FULL : EMPTY;
      FULL:    return promote ? DRAIN : FULL;
      DRAIN:   return finish ? EMPTY : DRAIN;
      default: return EMPTY;
    endcase
  endfunction

  // Round-half-up arithmetic shift, clamped to a dw-bit signed range; bit 32 is the guard bit.
  function automatic logic signed [31:0] round_sat(logic signed [31:0] x, logic [3:0] sh,
                                                   int unsigned dw);
    logic signed [32:0] sum;
    logic signed [32:0] lim_hi;
    logic signed [32:0] lim_lo;
    sum = {x[31], x};
    if (sh != 4'd0) sum = sum + (33'sd1 <<< (sh - 4'd1));
    sum = sum >>> sh;
    lim_hi = (33'sd1 <<< (dw - 1)) - 33'sd1;
    lim_lo = -(33'sd1 <<< (dw - 1));
    if (sum > lim_hi) sum = lim_hi;
    else if (sum < lim_lo) sum = lim_lo;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/ifft_pingpong_obuf_if.sv
// Frame capture and sample streaming handshake of the IFFT output buffer.
interface ifft_pingpong_obuf_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16
);
  localparam int ADDR_W = $clog2(N);

  logic                         store;
  logic                         store_ready;
  logic [N-1:0][DATA_WIDTH-1:0] real_in;
  logic [N-1:0][DATA_WIDTH-1:0] imag_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_real;
  logic signed [DATA_WIDTH-1:0] out_imag;
  logic [ADDR_W-1:0]            out_idx;
  logic                         out_last;

  modport slave (
    input  store, real_in, imag_in, out_ready,
    output store_ready, out_valid, out_real, out_imag, out_idx, out_last
  );

  modport master (
    output store, real_in, imag_in, out_ready,
    input  store_ready, out_valid, out_real, out_imag, out_idx, out_last
  );
endinterface

// File: rtl/obuf_bank.sv
// One frame bank: N complex sample registers loaded in parallel, read by index.
module obuf_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [N-1:0][DATA_WIDTH-1:0] real_in,
  input  logic [N-1:0][DATA_WIDTH-1:0] imag_in,
  input  logic [$clog2(N)-1:0]         idx,
  output logic signed [DATA_WIDTH-1:0] rd_real,
  output logic signed [DATA_WIDTH-1:0] rd_imag
);
  logic [N-1:0][DATA_WIDTH-1:0] mem_real;
  logic [N-1:0][DATA_WIDTH-1:0] mem_imag;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_real <= '0;
      mem_imag <= '0;
    end else if (load) begin
      mem_real <= real_in;
      mem_imag <= imag_in;
    end
  end

  assign rd_real = mem_real[idx];
  assign rd_imag = mem_imag[idx];
endmodule

// File: rtl/ifft_pingpong_obuf.sv
// Ping-pong output buffer: single-cycle frame capture, per-sample handshaked drain.
// Define OBUF_SHIFT_EN to add the shift port and rounding/saturating output scaling.
module ifft_pingpong_obuf
  import obuf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  ifft_pingpong_obuf_if.slave bus,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  input  logic             clear_ovf
`ifdef OBUF_SHIFT_EN
  ,
  input  logic [3:0]       shift
`endif
);
  localparam int ADDR_W = $clog2(N);

  bank_state_e                  state     [2];
  bank_state_e                  state_nxt [2];
  logic                         wp;
  logic                         rp;
  logic [ADDR_W-1:0]            ri;
  logic                         accept;
  logic                         drop;
  logic                         target;
  logic                         xfer;
  logic                         last_xfer;
  logic [1:0]                   load;
  logic signed [DATA_WIDTH-1:0] bank_real [2];
  logic signed [DATA_WIDTH-1:0] bank_imag [2];
  logic signed [DATA_WIDTH-1:0] raw_real;
  logic signed [DATA_WIDTH-1:0] raw_imag;

  assign bus.store_ready = (state[0] == EMPTY) || (state[1] == EMPTY);
  assign bus.out_valid   = (state[rp] == DRAIN);
  assign target          = (state[wp] == EMPTY) ? wp : ~wp;
  assign accept          = bus.store && bus.store_ready;
  assign drop            = bus.store && !bus.store_ready;
  assign xfer            = bus.out_valid && bus.out_ready;
  assign last_xfer       = xfer && (ri == ADDR_W'(N - 1));
  assign load[0]         = accept && (target == 1'b0);
  assign load[1]         = accept && (target == 1'b1);

  // The idle bank may promote on the last transfer of the draining one, avoiding a bubble.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      state_nxt[b] = next_bank_state(state[b], load[b],
                                     (state[b] == FULL) && ((1'(b) == rp) || last_xfer),
                                     last_xfer && (1'(b) == rp));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state[0]   <= EMPTY;
      state[1]   <= EMPTY;
      wp         <= 1'b0;
      rp         <= 1'b0;
      ri         <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state[0] <= state_nxt[0];
      state[1] <= state_nxt[1];
      if (accept) wp <= ~target;
      if (last_xfer) begin
        rp <= ~rp;
        ri <= '0;
      end else if (xfer) begin
        ri <= ri + 1'b1;
      end
      if (clear_ovf) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    obuf_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_bank (
      .clk     (clk),
      .reset   (reset),
      .load    (load[g]),
      .real_in (bus.real_in),
      .imag_in (bus.imag_in),
      .idx     (ri),
      .rd_real (bank_real[g]),
      .rd_imag (bank_imag[g])
    );
  end

  assign raw_real     = rp ? bank_real[1] : bank_real[0];
  assign raw_imag     = rp ? bank_imag[1] : bank_imag[0];
  assign bus.out_idx  = ri;
  assign bus.out_last = bus.out_valid && (ri == ADDR_W'(N - 1));

`ifdef OBUF_SHIFT_EN
  assign bus.out_real = DATA_WIDTH'(round_sat(32'(raw_real), shift, DATA_WIDTH));
  assign bus.out_imag = DATA_WIDTH'(round_sat(32'(raw_imag), shift, DATA_WIDTH));
`else
  assign bus.out_real = raw_real;
  assign bus.out_imag = raw_imag;
`endif
endmodule

// File: tb/tb_ifft_pingpong_obuf.sv
// Directed self-checking bench for ifft_pingpong_obuf (default build; shift case under OBUF_SHIFT_EN).
module tb_ifft_pingpong_obuf;
  localparam int DW = 16;
  localparam int NS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clear_ovf;
  int         n_pass   = 0;
  int         n_checks = 0;

  ifft_pingpong_obuf_if #(.DATA_WIDTH(DW), .N(NS)) bus ();

`ifdef OBUF_SHIFT_EN
  logic [3:0] shift;
`endif

  ifft_pingpong_obuf #(.DATA_WIDTH(DW), .N(NS), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clear_ovf  (clear_ovf)
`ifdef OBUF_SHIFT_EN
    ,
    .shift      (shift)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string tag, longint got, longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(int base);
    for (int k = 0; k < NS; k++) begin
      bus.real_in[k] = DW'(base + k);
      bus.imag_in[k] = DW'(-(base + k));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Expects a contiguous run of transfers (out_ready held high) of frame with given base.
  task automatic read_frame(string tag, int base);
    for (int k = 0; k < NS; k++) begin
      check({tag, "_valid"}, bus.out_valid, 1);
      check({tag, "_real"}, bus.out_real, base + k);
      check({tag, "_imag"}, bus.out_imag, -(base + k));
      check({tag, "_idx"}, bus.out_idx, k);
      check({tag, "_last"}, bus.out_last, (k == NS - 1) ? 1 : 0);
      tick();
    end
  endtask

  initial begin
    bus.store     = 1'b0;
    bus.out_ready = 1'b0;
    clear_ovf     = 1'b0;
    set_frame(0);
`ifdef OBUF_SHIFT_EN
    shift = 4'd0;
`endif
    #1;
    do_reset();

    check("rst_store_ready", bus.store_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_real", bus.out_real, 0);
    check("rst_out_imag", bus.out_imag, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);

    // Single frame: one-edge promotion latency, then 16 consecutive samples.
    bus.out_ready = 1'b1;
    set_frame(0);
    bus.store = 1'b1;
    tick();
    bus.store = 1'b0;
    check("t1_valid_full", bus.out_valid, 0);
    tick();
    read_frame("t1", 0);
    check("t1_valid_done", bus.out_valid, 0);
    check("t1_ready_done", bus.store_ready, 1);

    // Back-to-back frames with no bubble between them.
    set_frame(0);
    bus.store = 1'b1;
    tick();
    set_frame(100);
    tick();
    bus.store = 1'b0;
    check("t2_store_ready", bus.store_ready, 0);
    read_frame("t2a", 0);
    read_frame("t2b", 100);
    check("t2_valid_done", bus.out_valid, 0);

    // Stalled consumer: third store dropped, clear_ovf wins over a concurrent drop.
    bus.out_ready = 1'b0;
    set_frame(0);
    bus.store = 1'b1;
    tick();
    set_frame(100);
    tick();
    set_frame(200);
    tick();
    check("t3_overflow", overflow, 1);
    check("t3_drop_1", drop_count, 1);
    tick();
    check("t3_drop_2", drop_count, 2);
    clear_ovf = 1'b1;
    tick();
    bus.store = 1'b0;
    clear_ovf = 1'b0;
    check("t3_clr_ovf", overflow, 0);
    check("t3_clr_cnt", drop_count, 0);
    bus.out_ready = 1'b1;
    read_frame("t3a", 0);
    read_frame("t3b", 100);
    check("t3_valid_done", bus.out_valid, 0);

    // Alternating out_ready: sample held while stalled, frame done in 32 cycles.
    bus.out_ready = 1'b0;
    set_frame(50);
    bus.store = 1'b1;
    tick();
    bus.store = 1'b0;
    tick();
    begin
      int exp_k = 0;
      for (int c = 0; c < 2 * NS; c++) begin
        bus.out_ready = c[0];
        check("t4_valid", bus.out_valid, 1);
        check("t4_real", bus.out_real, 50 + exp_k);
        check("t4_idx", bus.out_idx, exp_k);
        tick();
        if (c[0]) exp_k++;
      end
    end
    check("t4_valid_done", bus.out_valid, 0);

    // Reset mid-frame after a drop has been recorded.
    bus.out_ready = 1'b1;
    set_frame(0);
    bus.store = 1'b1;
    tick();
    set_frame(100);
    tick();
    set_frame(200);
    tick();
    bus.store = 1'b0;
    check("t5_drop", drop_count, 1);
    for (int k = 1; k < 7; k++) tick();
    check("t5_idx7", bus.out_idx, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_valid", bus.out_valid, 0);
    check("t5_store_ready", bus.store_ready, 1);
    check("t5_drop_cnt", drop_count, 0);
    check("t5_overflow", overflow, 0);

`ifdef OBUF_SHIFT_EN
    shift = 4'd2;
    set_frame(0);
    bus.real_in[0] = 16'sd7;
    bus.real_in[1] = 16'h7FFF;
    bus.store = 1'b1;
    tick();
    bus.store = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    check("sh_7", bus.out_real, 2);
    bus.out_ready = 1'b1;
    tick();
    check("sh_7fff", bus.out_real, 16'h2000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ifft_pingpong_obuf.md
# ifft_pingpong_obuf

Double-buffered (ping-pong) output buffer between the IFFT core and downstream consumers of the DSP accelerator chiplet. It captures a complete N-point complex frame in one cycle into whichever of two banks is free. It then streams that frame out one sample per handshake while the other bank accepts the next frame, so the IFFT never stalls on a slow reader. Drops are flagged and counted.

## Interface
- DATA_WIDTH, 16, bits per real/imag sample (signed)
- N, 16, samples per frame (power of two, ≥2)
- ADDR_W, $clog2(N), sample index width (derived, not overridden)
- CNT_W, 8, drop counter width
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- store  in  1  capture real_in/imag_in this cycle
- store_ready  out  1  at least one bank EMPTY
- real_in  in  DATA_WIDTH×N  signed frame, real parts
- imag_in  in  DATA_WIDTH×N  signed frame, imag parts
- out_valid  out  1  a sample is presented
- out_ready  in  1  consumer accepts sample
- out_real  out  DATA_WIDTH  signed sample, real
- out_imag  out  DATA_WIDTH  signed sample, imag
- out_idx  out  ADDR_W  index of presented sample within frame
- out_last  out  1  presented sample is index N-1
- overflow  out  1  sticky: a store was dropped
- drop_count  out  CNT_W  saturating count of dropped stores
- clear_ovf  in  1  clears overflow and drop_count
- shift  in  4  right-shift amount (present only with OBUF_SHIFT_EN)

## Operation
- Two banks, each with a state: EMPTY, FULL, DRAIN. Reset: both EMPTY, write pointer wp=0, read pointer rp=0, sample index ri=0, overflow=0, drop_count=0, contents zeroed.
- Store accepted when store && store_ready. Target is bank wp if EMPTY, otherwise bank !wp. All N samples are latched at the edge, the bank goes FULL, and wp toggles to the other bank.
- Store while !store_ready: the data is discarded, overflow is set, and drop_count increments, saturating at 2^CNT_W-1.
- Read side: when bank rp is FULL it moves to DRAIN with ri=0. While bank rp is in DRAIN, out_valid=1. The outputs are a combinational mux of bank rp at index ri, so there is no read latency.
- Transfer happens on out_valid && out_ready: ri increments. On the transfer with ri=N-1, bank rp goes EMPTY, rp toggles, and ri returns to 0.
- Frames leave strictly in capture order. Capture order is preserved because wp and rp both alternate.
- clear_ovf has priority over a same-cycle drop: counter ends at 0 and overflow at 0.
- Banks in DRAIN or FULL are never overwritten.

## Timing
- Reset values of outputs: store_ready=1, out_valid=0, out_real/out_imag=0, out_idx=0, out_last=0, overflow=0, drop_count=0.
- Store to first sample: a store at edge t gives out_valid=1 after edge t+1. The FULL→DRAIN promotion takes one edge.
- If the other bank is FULL at the last transfer, it goes directly to DRAIN on that same edge. out_valid stays high with no bubble, and sample 0 of the next frame is presented in the next cycle.
- store_ready is derived from the registered bank states. A bank freed at edge t is usable by a store sampled at edge t+1, not at edge t.
- A simultaneous store and last transfer is legal. The store targets the EMPTY bank if one exists, otherwise it is dropped.
- When out_ready is low, all outputs hold stable.
- Reset mid-frame aborts everything: both banks go EMPTY and in-flight data is lost.

## Configuration
- OBUF_SHIFT_EN defined: the shift port exists. Each output component is (x + 2^(shift-1)) >>> shift, with shift=0 meaning no rounding term. The result is saturated to DATA_WIDTH using one guard bit.
- OBUF_SHIFT_EN undefined: there is no shift port and samples pass through unmodified.

## Structure
- Package obuf_pkg holds:
  - bank_state_e (EMPTY, FULL, DRAIN)
  - a function computing next bank state
  - the rounding/saturation function used under OBUF_SHIFT_EN
- Sub-module obuf_bank: one bank's N×2 sample registers, the load enable, and the indexed read mux. It is instantiated twice.

## Test plan
- Reset, then one store of real_in[k]=k, imag_in[k]=-k with out_ready=1 → out_valid rises one cycle later. Samples 0..15 appear on 16 consecutive cycles, out_last only on index 15, then out_valid=0.
- Two stores on consecutive cycles, frame A then B, out_ready=1 → 32 back-to-back samples, A then B, with no bubble. store_ready=0 after the second store.
- Three stores while out_ready=0 → the third is dropped. overflow=1 and drop_count=1; A and B are intact. Pulsing clear_ovf returns both to 0.
- out_ready toggling every other cycle → each sample is held stable while out_ready=0, and the frame completes in 32 cycles.
- Reset asserted at sample 7 → next cycle out_valid=0, store_ready=1, drop_count=0.
- OBUF_SHIFT_EN with shift=2 and input 7 → output 2. With input 0x7FFF → output 0x2000 (rounded, no overflow).
